decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipelined, handshaked RV32I instruction decode stage with optional M-extension. It sits between the fetch stage and the execute stage. It registers all decoded control fields behind a valid/ready interface and contains a one-entry skid buffer, so `in_ready_o` is a registered signal. It adds strict illegal-instruction checking on funct3/funct7 and a pipeline flush.

Parameters:
XLEN, 32, width of pc_i/pc_o.
ENABLE_M, 0, 1 = decode MUL/DIV (funct7=0000001 on OP) as legal; 0 = treat as illegal.
STRICT_DECODE, 1, 1 = check funct3/funct7/inst[1:0] legality per opcode; 0 = flag only unknown opcodes.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  drop all held and in-flight instructions
in_valid_i  in  1  fetch presents instruction
in_ready_o  out  1  stage can accept (registered)
instruction_i  in  32  instruction word
pc_i  in  XLEN  PC of instruction_i
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  execute accepts bundle
instruction_o  out  32  registered instruction
pc_o  out  XLEN  registered PC
funct3_o  out  3  inst[14:12]
rs1_o, rs2_o, rd_o  out  5 each  inst[19:15], [24:20], [11:7]
csr_addr_o  out  12  inst[31:20]
imm_op_o  out  3  I=000 S=001 B=010 U=011 J=100 C=101
sel_dat_a_o  out  2  REG=00 IMM=01 PC=10 ZERO=11
sel_dat_b_o  out  2  same encoding
alu_op_o  out  4  ADD=0000 SUB=1000 SLL=0001 SLT=0010 SLTU=0011 XOR=0100 SRL=0101 SRA=1101 OR=0110 AND=0111
is_lui_o, is_auipc_o, is_jal_o, is_jalr_o, is_branch_o, is_mem_o, we_mem_o, is_misc_mem_o, is_system_o  out  1 each  class flags
is_muldiv_o  out  1  M-extension op; funct3_o selects the operation
e_illegal_inst_o  out  1  illegal instruction

Behaviour:
- Reset is synchronous and active-high on clk_i.
  - Reset values: out_valid_o=0, in_ready_o=1, skid empty.
  - All data outputs reset to 0 except sel_dat_a_o=00, sel_dat_b_o=00 and alu_op_o=ADD.
- Decode is combinational on the incoming word and registered into the output stage.
  - Latency: 1 cycle from an accepted input to out_valid_o.
- Defaults per decode: all flags 0, sel a/b=REG, imm_op=I, alu_op=ADD.
- Decode table (sel_a / sel_b / imm / alu):
  - LUI: IMM/ZERO/U/ADD.
  - AUIPC: PC/IMM/U/ADD.
  - JAL: PC/IMM/J/ADD.
  - JALR: REG/IMM/I/ADD.
  - BRANCH: REG/REG/B; alu_op=SUB.
  - LOAD: REG/IMM/I/ADD, is_mem.
  - STORE: REG/IMM/S/ADD, is_mem, we_mem.
  - OP_IMM: REG/IMM/I; alu_op={inst[30] & (funct3==101), funct3}, so ADDI never becomes SUB.
  - OP: REG/REG; alu_op={inst[30], funct3}; if ENABLE_M and funct7=0000001, is_muldiv=1 and alu_op=ADD.
  - MISC_MEM: is_misc_mem.
  - SYSTEM: is_system; imm_op=C; sel_a=IMM when funct3[2]=1, else REG.
  - Any other opcode: e_illegal=1.
- STRICT_DECODE=1 additionally flags illegal when any of the following holds:
  - inst[1:0]≠11.
  - JALR with funct3≠000.
  - BRANCH with funct3 ∈ {010, 011}.
  - LOAD with funct3 ∈ {011, 110, 111}.
  - STORE with funct3 ≥ 011.
  - OP_IMM SLLI with funct7≠0.
  - OP_IMM SRLI/SRAI with funct7 ∉ {0000000, 0100000}.
  - OP with funct7=0100000 and funct3 ∉ {000, 101}.
  - OP with any other funct7 not in {0000000, 0100000, 0000001 (ENABLE_M only)}.
  - SYSTEM with funct3=100.
- When e_illegal=1, all class flags, is_muldiv_o and we_mem_o are forced to 0. The bundle is still delivered so execute can trap.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Skid buffer:
  - If an input transfers while the output register is full and not draining, the decoded bundle goes to the skid entry and in_ready_o drops next cycle.
  - When the output drains, skid contents move to the output register; in_ready_o rises next cycle.
  - Order is preserved, with no bubbles under continuous flow: one instruction per cycle when out_ready_i=1.
- Simultaneous accept and drain with the skid empty: the new bundle loads directly into the output register and out_valid_o stays 1.
- flush_i has priority over every other event.
  - Next cycle: out_valid_o=0, skid emptied, in_ready_o=1.
  - An input presented in the flush cycle is discarded.
- rst_i mid-transfer behaves identically to flush plus resetting all outputs to their reset values.

Test Plan:
1. Reset, then ADDI x1,x0,5 (0x00500093) with out_ready_i=1 → next cycle out_valid_o=1, rd_o=1, rs1_o=0, imm_op_o=000, sel_dat_b_o=01, alu_op_o=0000, e_illegal_inst_o=0.
2. SUB x3,x1,x2 (0x402081B3) → alu_op_o=1000, sel a/b=00/00. Then 0x022081B3 with ENABLE_M=0 → e_illegal_inst_o=1; with ENABLE_M=1 → is_muldiv_o=1, funct3_o=000, e_illegal_inst_o=0.
3. Back-to-back stream of 4 instructions with out_ready_i held 0 from cycle 2 → first bundle held stable, second captured in skid, in_ready_o=0 from cycle 3. Release out_ready_i → bundles emerge in order at 1 per cycle with no loss or duplication.
4. Issue flush_i while out_valid_o=1 and the skid is full → next cycle out_valid_o=0, in_ready_o=1; the input presented in the flush cycle never appears at the output.
5. Illegal words 0x00000000 and 0x0000706F (JAL rd=0 funct3 ignored, legal) with STRICT_DECODE=1 → first gives e_illegal=1 with all class flags 0, second gives is_jal_o=1 and imm_op_o=100. Also 0x00001067 (JALR funct3=001) → e_illegal=1.
6. CSRRWI (0x34015073) → is_system_o=1, sel_dat_a_o=01, imm_op_o=101, csr_addr_o=0x340.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) handshaked decode stage with one-entry skid buffer
module decode_stage #(
    parameter int XLEN          = 32,
    parameter int ENABLE_M      = 0,
    parameter int STRICT_DECODE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     instruction_o,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [11:0]     csr_addr_o,
    output logic [2:0]      imm_op_o,
    output logic [1:0]      sel_dat_a_o,
    output logic [1:0]      sel_dat_b_o,
    output logic [3:0]      alu_op_o,
    output logic            is_lui_o,
    output logic            is_auipc_o,
    output logic            is_jal_o,
    output logic            is_jalr_o,
    output logic            is_branch_o,
    output logic            is_mem_o,
    output logic            we_mem_o,
    output logic            is_misc_mem_o,
    output logic            is_system_o,
    output logic            is_muldiv_o,
    output logic            e_illegal_inst_o
);

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011, IMM_J = 3'b100, IMM_C = 3'b101;
    localparam logic [1:0] SEL_REG = 2'b00, SEL_IMM = 2'b01, SEL_PC = 2'b10, SEL_ZERO = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [2:0]      imm_op;
        logic [1:0]      sel_a;
        logic [1:0]      sel_b;
        logic [3:0]      alu_op;
        logic            is_lui;
        logic            is_auipc;
        logic            is_jal;
        logic            is_jalr;
        logic            is_branch;
        logic            is_mem;
        logic            we_mem;
        logic            is_misc_mem;
        logic            is_system;
        logic            is_muldiv;
        logic            illegal;
    } bundle_t;

    bundle_t     dec;
    bundle_t     out_q;
    bundle_t     skid_q;
    logic        out_valid_q;
    logic        skid_valid_q;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        unknown;
    logic        strict_bad;

    assign f3 = instruction_i[14:12];
    assign f7 = instruction_i[31:25];

    always_comb begin
        dec        = '0;
        dec.inst   = instruction_i;
        dec.pc     = pc_i;
        unknown    = 1'b0;
        strict_bad = (instruction_i[1:0] != 2'b11);
        case (instruction_i[6:2])
            5'b01101: begin
                dec.sel_a = SEL_IMM; dec.sel_b = SEL_ZERO; dec.imm_op = IMM_U; dec.is_lui = 1'b1;
            end
            5'b00101: begin
                dec.sel_a = SEL_PC; dec.sel_b = SEL_IMM; dec.imm_op = IMM_U; dec.is_auipc = 1'b1;
            end
            5'b11011: begin
                dec.sel_a = SEL_PC; dec.sel_b = SEL_IMM; dec.imm_op = IMM_J; dec.is_jal = 1'b1;
            end
            5'b11001: begin
                dec.sel_b = SEL_IMM; dec.is_jalr = 1'b1;
                if (f3 != 3'b000) strict_bad = 1'b1;
            end
            5'b11000: begin
                dec.imm_op = IMM_B; dec.alu_op = ALU_SUB; dec.is_branch = 1'b1;
                if (f3[2:1] == 2'b01) strict_bad = 1'b1;
            end
            5'b00000: begin
                dec.sel_b = SEL_IMM; dec.is_mem = 1'b1;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) strict_bad = 1'b1;
            end
            5'b01000: begin
                dec.sel_b = SEL_IMM; dec.imm_op = IMM_S; dec.is_mem = 1'b1; dec.we_mem = 1'b1;
                if (f3 >= 3'b011) strict_bad = 1'b1;
            end
            5'b00100: begin
                // Only shifts honour inst[30], so an ADDI with imm[10] set stays ADD.
                dec.sel_b  = SEL_IMM;
                dec.alu_op = {instruction_i[30] & (f3 == 3'b101), f3};
                if (f3 == 3'b001 && f7 != 7'b0000000) strict_bad = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) strict_bad = 1'b1;
            end
            5'b01100: begin
                if (f7 == 7'b0000001) begin
                    if (ENABLE_M != 0) dec.is_muldiv = 1'b1;
                    else               unknown = 1'b1;
                end else begin
                    dec.alu_op = {instruction_i[30], f3};
                    if (f7 == 7'b0100000) begin
                        if (f3 != 3'b000 && f3 != 3'b101) strict_bad = 1'b1;
                    end else if (f7 != 7'b0000000) begin
                        strict_bad = 1'b1;
                    end
                end
            end
            5'b00011: dec.is_misc_mem = 1'b1;
            5'b11100: begin
                dec.is_system = 1'b1; dec.imm_op = IMM_C;
                dec.sel_a     = f3[2] ? SEL_IMM : SEL_REG;
                if (f3 == 3'b100) strict_bad = 1'b1;
            end
            default: unknown = 1'b1;
        endcase

        dec.illegal = unknown | ((STRICT_DECODE != 0) & strict_bad);
        // Illegal words still travel down the pipe, but must not trigger any side effect.
        if (dec.illegal) begin
            dec.is_lui = 1'b0; dec.is_auipc = 1'b0; dec.is_jal = 1'b0; dec.is_jalr = 1'b0;
            dec.is_branch = 1'b0; dec.is_mem = 1'b0; dec.we_mem = 1'b0;
            dec.is_misc_mem = 1'b0; dec.is_system = 1'b0; dec.is_muldiv = 1'b0;
        end
    end

    logic in_xfer;
    logic out_free;

    // in_ready is the inverse of a flop, so it never depends on out_ready_i combinationally.
    assign in_ready_o = ~skid_valid_q;
    assign in_xfer    = in_valid_i & in_ready_o;
    assign out_free   = ~out_valid_q | out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_xfer) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign instruction_o    = out_q.inst;
    assign pc_o             = out_q.pc;
    assign funct3_o         = out_q.inst[14:12];
    assign rs1_o            = out_q.inst[19:15];
    assign rs2_o            = out_q.inst[24:20];
    assign rd_o             = out_q.inst[11:7];
    assign csr_addr_o       = out_q.inst[31:20];
    assign imm_op_o         = out_q.imm_op;
    assign sel_dat_a_o      = out_q.sel_a;
    assign sel_dat_b_o      = out_q.sel_b;
    assign alu_op_o         = out_q.alu_op;
    assign is_lui_o         = out_q.is_lui;
    assign is_auipc_o       = out_q.is_auipc;
    assign is_jal_o         = out_q.is_jal;
    assign is_jalr_o        = out_q.is_jalr;
    assign is_branch_o      = out_q.is_branch;
    assign is_mem_o         = out_q.is_mem;
    assign we_mem_o         = out_q.we_mem;
    assign is_misc_mem_o    = out_q.is_misc_mem;
    assign is_system_o      = out_q.is_system;
    assign is_muldiv_o      = out_q.is_muldiv;
    assign e_illegal_inst_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic in_ready, out_valid;
    logic [31:0] inst_o, pc_o;
    logic [2:0] funct3, imm_op;
    logic [4:0] rs1, rs2, rd;
    logic [11:0] csr;
    logic [1:0] sel_a, sel_b;
    logic [3:0] alu_op;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_mem, we_mem, is_misc, is_sys, is_muldiv, illegal;

    logic m_in_ready, m_out_valid;
    logic [31:0] m_inst_o, m_pc_o;
    logic [2:0] m_funct3, m_imm_op;
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic [11:0] m_csr;
    logic [1:0] m_sel_a, m_sel_b;
    logic [3:0] m_alu_op;
    logic m_is_lui, m_is_auipc, m_is_jal, m_is_jalr, m_is_branch, m_is_mem, m_we_mem, m_is_misc, m_is_sys, m_is_muldiv, m_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    decode_stage #(.XLEN(32), .ENABLE_M(0), .STRICT_DECODE(1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instruction_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .instruction_o(inst_o), .pc_o(pc_o), .funct3_o(funct3), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .csr_addr_o(csr), .imm_op_o(imm_op), .sel_dat_a_o(sel_a), .sel_dat_b_o(sel_b), .alu_op_o(alu_op),
        .is_lui_o(is_lui), .is_auipc_o(is_auipc), .is_jal_o(is_jal), .is_jalr_o(is_jalr),
        .is_branch_o(is_branch), .is_mem_o(is_mem), .we_mem_o(we_mem), .is_misc_mem_o(is_misc),
        .is_system_o(is_sys), .is_muldiv_o(is_muldiv), .e_illegal_inst_o(illegal)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1), .STRICT_DECODE(1)) dut_m (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(m_in_ready),
        .instruction_i(instr), .pc_i(pc), .out_valid_o(m_out_valid), .out_ready_i(out_ready),
        .instruction_o(m_inst_o), .pc_o(m_pc_o), .funct3_o(m_funct3), .rs1_o(m_rs1), .rs2_o(m_rs2), .rd_o(m_rd),
        .csr_addr_o(m_csr), .imm_op_o(m_imm_op), .sel_dat_a_o(m_sel_a), .sel_dat_b_o(m_sel_b), .alu_op_o(m_alu_op),
        .is_lui_o(m_is_lui), .is_auipc_o(m_is_auipc), .is_jal_o(m_is_jal), .is_jalr_o(m_is_jalr),
        .is_branch_o(m_is_branch), .is_mem_o(m_is_mem), .we_mem_o(m_we_mem), .is_misc_mem_o(m_is_misc),
        .is_system_o(m_is_sys), .is_muldiv_o(m_is_muldiv), .e_illegal_inst_o(m_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1; instr = w; pc = p; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        step(); step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if ({inst_o, alu_op, sel_a, sel_b, imm_op} !== 43'd0) begin n_bad++; $display("FAIL rst_data: got inst %08h alu %0h sel %0h/%0h imm %0h want zeros", inst_o, alu_op, sel_a, sel_b, imm_op); end
    endtask

    task automatic test_addi();
        issue(32'h00500093, 32'h100);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
        n_cmp++; if ({rd, rs1} !== {5'd1, 5'd0}) begin n_bad++; $display("FAIL addi_regs: got rd %0d rs1 %0d want 1 0", rd, rs1); end
        n_cmp++; if ({imm_op, sel_a, sel_b, alu_op} !== {3'b000, 2'b00, 2'b01, 4'b0000}) begin n_bad++; $display("FAIL addi_ctrl: got imm %0b a %0b b %0b alu %0b want 000 00 01 0000", imm_op, sel_a, sel_b, alu_op); end
        n_cmp++; if ({illegal, pc_o} !== {1'b0, 32'h100}) begin n_bad++; $display("FAIL addi_ill_pc: got ill %0b pc %0h want 0 100", illegal, pc_o); end
        issue(32'h40008093, 32'h104);
        n_cmp++; if (alu_op !== 4'b0000) begin n_bad++; $display("FAIL addi_bit30: got alu %0b want 0000", alu_op); end
        issue(32'h4030D093, 32'h108);
        n_cmp++; if ({alu_op, illegal} !== {4'b1101, 1'b0}) begin n_bad++; $display("FAIL srai: got alu %0b ill %0b want 1101 0", alu_op, illegal); end
        issue(32'h40309093, 32'h10C);
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL slli_f7: got ill %0b want 1", illegal); end
    endtask

    task automatic test_op_muldiv();
        issue(32'h402081B3, 32'h200);
        n_cmp++; if ({alu_op, sel_a, sel_b, illegal} !== {4'b1000, 2'b00, 2'b00, 1'b0}) begin n_bad++; $display("FAIL sub: got alu %0b a %0b b %0b ill %0b want 1000 00 00 0", alu_op, sel_a, sel_b, illegal); end
        issue(32'h022081B3, 32'h204);
        n_cmp++; if ({illegal, is_muldiv} !== 2'b10) begin n_bad++; $display("FAIL mul_nom: got ill %0b muldiv %0b want 1 0", illegal, is_muldiv); end
        n_cmp++; if ({m_illegal, m_is_muldiv, m_funct3, m_alu_op} !== {1'b0, 1'b1, 3'b000, 4'b0000}) begin n_bad++; $display("FAIL mul_m: got ill %0b muldiv %0b f3 %0b alu %0b want 0 1 000 0000", m_illegal, m_is_muldiv, m_funct3, m_alu_op); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        int exp_cyc [4];
        logic [31:0] recv [$];
        int rcyc [$];
        int idx;
        logic xin;
        seq[0] = 32'h00100093; seq[1] = 32'h00200113; seq[2] = 32'h00300193; seq[3] = 32'h00400213;
        exp_cyc[0] = 1; exp_cyc[1] = 6; exp_cyc[2] = 7; exp_cyc[3] = 8;
        idx = 0;
        // drain the bundle left over from the previous test
        out_ready = 1'b1; step();
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc < 2) || (cyc >= 6);
            in_valid  = (idx < 4);
            instr     = (idx < 4) ? seq[idx] : 32'h0;
            pc        = 32'h300 + idx * 4;
            if (cyc == 2) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_c2: got %0b want 1", in_ready); end
            end
            if (cyc >= 3 && cyc <= 5) begin
                n_cmp++; if ({out_valid, in_ready, inst_o} !== {1'b1, 1'b0, seq[1]}) begin n_bad++; $display("FAIL b2b_hold_c%0d: got v %0b rdy %0b inst %08h want 1 0 %08h", cyc, out_valid, in_ready, inst_o, seq[1]); end
            end
            xin = in_valid && in_ready;
            if (out_valid && out_ready) begin recv.push_back(inst_o); rcyc.push_back(cyc); end
            step();
            if (xin) idx++;
        end
        in_valid = 1'b0;
        n_cmp++; if (recv.size() !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", recv.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < recv.size()) begin
                n_cmp++; if ({recv[i], rcyc[i]} !== {seq[i], exp_cyc[i]}) begin n_bad++; $display("FAIL b2b_order%0d: got %08h@%0d want %08h@%0d", i, recv[i], rcyc[i], seq[i], exp_cyc[i]); end
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500293; pc = 32'h400;
        step();
        instr = 32'h00600313; pc = 32'h404;
        step();
        n_cmp++; if ({out_valid, in_ready, inst_o} !== {1'b1, 1'b0, 32'h00500293}) begin n_bad++; $display("FAIL flush_setup: got v %0b rdy %0b inst %08h want 1 0 00500293", out_valid, in_ready, inst_o); end
        flush = 1'b1; instr = 32'h00700393; pc = 32'h408;
        step();
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL flush_next: got v %0b rdy %0b want 0 1", out_valid, in_ready); end
        instr = 32'h00800413; pc = 32'h40C;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop_in: got v %0b want 0", out_valid); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_leak: got v %0b want 0", out_valid); end
        issue(32'h00900493, 32'h410);
        n_cmp++; if ({out_valid, inst_o} !== {1'b1, 32'h00900493}) begin n_bad++; $display("FAIL flush_recover: got v %0b inst %08h want 1 00900493", out_valid, inst_o); end
        in_valid = 1'b1; instr = 32'h00A00513; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready, inst_o} !== {1'b0, 1'b1, 32'h0}) begin n_bad++; $display("FAIL mid_reset: got v %0b rdy %0b inst %08h want 0 1 0", out_valid, in_ready, inst_o); end
    endtask

    task automatic test_illegal();
        issue(32'h00000000, 32'h500);
        n_cmp++; if ({illegal, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_mem, we_mem, is_misc, is_sys, is_muldiv} !== 11'b100_0000_0000) begin n_bad++; $display("FAIL ill_zero: got ill %0b flags %0b want 1 0", illegal, {is_lui, is_auipc, is_jal, is_jalr, is_branch, is_mem, we_mem, is_misc, is_sys, is_muldiv}); end
        issue(32'h0000706F, 32'h504);
        n_cmp++; if ({illegal, is_jal, imm_op, sel_a, sel_b} !== {1'b0, 1'b1, 3'b100, 2'b10, 2'b01}) begin n_bad++; $display("FAIL jal: got ill %0b jal %0b imm %0b a %0b b %0b want 0 1 100 10 01", illegal, is_jal, imm_op, sel_a, sel_b); end
        issue(32'h00001067, 32'h508);
        n_cmp++; if ({illegal, is_jalr} !== 2'b10) begin n_bad++; $display("FAIL jalr_f3: got ill %0b jalr %0b want 1 0", illegal, is_jalr); end
        issue(32'h0020B023, 32'h50C);
        n_cmp++; if ({illegal, is_mem, we_mem} !== 3'b100) begin n_bad++; $display("FAIL store_f3: got ill %0b mem %0b we %0b want 1 0 0", illegal, is_mem, we_mem); end
        issue(32'h0020A023, 32'h510);
        n_cmp++; if ({illegal, is_mem, we_mem, imm_op} !== {3'b011, 3'b001}) begin n_bad++; $display("FAIL store_ok: got ill %0b mem %0b we %0b imm %0b want 0 1 1 001", illegal, is_mem, we_mem, imm_op); end
    endtask

    task automatic test_system();
        issue(32'h34015073, 32'h600);
        n_cmp++; if ({is_sys, sel_a, imm_op, illegal} !== {1'b1, 2'b01, 3'b101, 1'b0}) begin n_bad++; $display("FAIL csrrwi: got sys %0b a %0b imm %0b ill %0b want 1 01 101 0", is_sys, sel_a, imm_op, illegal); end
        n_cmp++; if (csr !== 12'h340) begin n_bad++; $display("FAIL csr_addr: got %03h want 340", csr); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_op_muldiv();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_system();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
